// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host byte receiver: synchronises PS2_CLK/PS2_DAT, deframes 11-bit frames.
// Optional PS2_RX_DEGLITCH_EN adds a stable-sample filter on the synced PS2_CLK.
module ps2_rx_frame #(
   parameter int TIMEOUT_CYCLES  = 100000
`ifdef PS2_RX_DEGLITCH_EN
   ,
   parameter int DEGLITCH_CYCLES = 8
`endif
) (
   input  logic       CLOCK,
   input  logic       reset,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] received_data,
   output logic       received_data_en,
   output logic       parity_error,
   output logic       frame_error,
   output logic       busy
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] STOP   = 2'd3;

   logic          ps2_clk_p0, ps2_clk_p1;
   logic          ps2_dat_p0, ps2_dat_p1;
   logic          clk_lvl;
   logic          clk_prev;
   logic          fall;
   logic [1:0]    state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          par_ok;
   logic [TW-1:0] to_cnt;

   function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

   // Stage p0/p1: two-flop synchronisers, idle-high
   always_ff @(posedge CLOCK or posedge reset) begin
      if (reset) begin
         ps2_clk_p0 <= 1'b1;
         ps2_clk_p1 <= 1'b1;
         ps2_dat_p0 <= 1'b1;
         ps2_dat_p1 <= 1'b1;
      end else begin
         ps2_clk_p0 <= PS2_CLK;
         ps2_clk_p1 <= ps2_clk_p0;
         ps2_dat_p0 <= PS2_DAT;
         ps2_dat_p1 <= ps2_dat_p0;
      end
   end

`ifdef PS2_RX_DEGLITCH_EN
   localparam int DW = $clog2(DEGLITCH_CYCLES + 1);
   logic [DW-1:0] dg_cnt;
   logic          clk_filt;

   // Filtered level follows the synced clock only after a full run of differing samples
   always_ff @(posedge CLOCK or posedge reset) begin
      if (reset) begin
         clk_filt <= 1'b1;
         dg_cnt   <= '0;
      end else if (ps2_clk_p1 == clk_filt) begin
         dg_cnt <= '0;
      end else if (dg_cnt == DW'(DEGLITCH_CYCLES - 1)) begin
         clk_filt <= ps2_clk_p1;
         dg_cnt   <= '0;
      end else begin
         dg_cnt <= dg_cnt + 1'b1;
      end
   end

   assign clk_lvl = clk_filt;
`else
   assign clk_lvl = ps2_clk_p1;
`endif

   assign fall = clk_prev & ~clk_lvl;
   assign busy = (state != IDLE);

   // Stage p2: frame state machine, timeout and registered output pulses
   always_ff @(posedge CLOCK or posedge reset) begin
      if (reset) begin
         clk_prev         <= 1'b1;
         state            <= IDLE;
         bit_cnt          <= 3'd0;
         shift            <= 8'd0;
         par_ok           <= 1'b0;
         to_cnt           <= '0;
         received_data    <= 8'd0;
         received_data_en <= 1'b0;
         parity_error     <= 1'b0;
         frame_error      <= 1'b0;
      end else begin
         clk_prev         <= clk_lvl;
         received_data_en <= 1'b0;
         parity_error     <= 1'b0;
         frame_error      <= 1'b0;
         if (fall) begin
            // An edge always wins over a coincident timeout expiry
            to_cnt <= '0;
            case (state)
               IDLE: begin
                  if (!ps2_dat_p1) begin
                     state   <= DATA;
                     bit_cnt <= 3'd0;
                  end
               end
               DATA: begin
                  shift <= {ps2_dat_p1, shift[7:1]};
                  if (bit_cnt == 3'd7) state <= PARITY;
                  else bit_cnt <= bit_cnt + 3'd1;
               end
               PARITY: begin
                  par_ok <= odd_parity_ok(shift, ps2_dat_p1);
                  state  <= STOP;
               end
               default: begin
                  if (!ps2_dat_p1) begin
                     frame_error <= 1'b1;
                  end else if (par_ok) begin
                     received_data    <= shift;
                     received_data_en <= 1'b1;
                  end else begin
                     parity_error <= 1'b1;
                  end
                  state <= IDLE;
               end
            endcase
         end else if (state == IDLE) begin
            to_cnt <= '0;
         end else if (to_cnt == TO_LAST) begin
            frame_error <= 1'b1;
            state       <= IDLE;
            to_cnt      <= '0;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

endmodule
